ctrl_unit: RTL and testbench

Control unit for the 6-instruction processor. It sits upstream of opblock and drives all of its select, address and strobe inputs. It also drives the instruction-memory read and the data-memory control lines.
- Multi-cycle Moore FSM: INIT, FETCH, DECODE, one execute state per opcode.
- Owns PC and IR. Only feedback from the datapath is rf_rp_zero.

---
 rtl/ctrl_pkg.sv | 108 ++++++++++
 rtl/ctrl_pc.sv | 39 +++
 rtl/ctrl_unit.sv | 110 +++++++++++
 tb/tb_ctrl_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ctrl_unit control FSM.
// The HALT state only exists when CTRL_HALT_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OpLoad  = 4'h0,
        OpStore = 4'h1,
        OpAdd   = 4'h2,
        OpLdc   = 4'h3,
        OpSub   = 4'h4,
        OpJmpz  = 4'h5,
        OpHalt  = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        StInit,
        StFetch,
        StDecode,
        StLoad,
        StStore,
        StAdd,
        StSub,
        StLdc,
        StJmpz,
`ifdef CTRL_HALT_EN
        StJmp,
        StHalt
`else
        StJmp
`endif
    } state_t;

    // Write-data mux select, shared with opblock
    localparam logic [1:0] RfSAlu   = 2'b00;
    localparam logic [1:0] RfSDreg  = 2'b01;
    localparam logic [1:0] RfSWdata = 2'b10;

    // ALU operation select, shared with opblock
    localparam logic [1:0] AluBypass = 2'b00;
    localparam logic [1:0] AluAdd    = 2'b01;
    localparam logic [1:0] AluSub    = 2'b10;

    typedef struct packed {
        logic       i_rd;
        logic       d_rd;
        logic       d_wr;
        logic       rf_w_wr;
        logic       rf_rp_rd;
        logic       rf_rq_rd;
        logic       rp_sel_b;
        logic [1:0] rf_s;
        logic [1:0] alu_s;
    } ctrl_out_t;

    // Execute state selected by an opcode; undefined opcodes fall back to FETCH.
    function automatic state_t exec_state(input logic [3:0] op);
        state_t st;
        st = StFetch;
        case (op)
            OpLoad:  st = StLoad;
            OpStore: st = StStore;
            OpAdd:   st = StAdd;
            OpLdc:   st = StLdc;
            OpSub:   st = StSub;
            OpJmpz:  st = StJmpz;
`ifdef CTRL_HALT_EN
            OpHalt:  st = StHalt;
`endif
            default: st = StFetch;
        endcase
        return st;
    endfunction

    // Moore output decode for a given state; everything not listed stays 0.
    function automatic ctrl_out_t ctrl_decode(input state_t st);
        ctrl_out_t o;
        o = '0;
        unique case (st)
            StFetch: o.i_rd = 1'b1;
            StLoad: begin
                o.d_rd    = 1'b1;
                o.rf_s    = RfSDreg;
                o.rf_w_wr = 1'b1;
            end
            StStore: begin
                o.d_wr     = 1'b1;
                o.rf_rp_rd = 1'b1;
                o.alu_s    = AluBypass;
            end
            StAdd, StSub: begin
                o.rf_rp_rd = 1'b1;
                o.rf_rq_rd = 1'b1;
                o.rp_sel_b = 1'b1;
                o.alu_s    = (st == StAdd) ? AluAdd : AluSub;
                o.rf_s     = RfSAlu;
                o.rf_w_wr  = 1'b1;
            end
            StLdc: begin
                o.rf_s    = RfSWdata;
                o.rf_w_wr = 1'b1;
            end
            StJmpz: o.rf_rp_rd = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_pc.sv
// Program counter: async-reset register with increment and relative load.
// A relative load applies PC + sext(offset) - 1, modulo 2**PcWidth.
module ctrl_pc #(
    parameter int unsigned PcWidth = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               inc_i,
    input  logic               ld_i,
    input  logic [7:0]         offset_i,
    output logic [PcWidth-1:0] pc_o
);

    logic [PcWidth-1:0] pc_q, pc_d;
    logic [PcWidth-1:0] offset_ext;

    assign offset_ext = PcWidth'($signed(offset_i));

    always_comb begin
        pc_d = pc_q;
        if (ld_i) begin
            // PC already points past the JMPZ, so the -1 makes the offset JMPZ-relative
            pc_d = pc_q + offset_ext - PcWidth'(1);
        end else if (inc_i) begin
            pc_d = pc_q + PcWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle Moore control unit for the 6-instruction processor.
// Optional HALT opcode (4'hF) enabled by defining CTRL_HALT_EN.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned REGBITS     = 4,
    parameter int unsigned DADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    i_addr,
    output logic                   i_rd,
    input  logic [15:0]            i_data,
    output logic [DADDR_WIDTH-1:0] d_addr,
    output logic                   d_rd,
    output logic                   d_wr,
    output logic [7:0]             rf_w_data,
    output logic [REGBITS-1:0]     rf_w_addr,
    output logic [REGBITS-1:0]     rf_rp_addr,
    output logic [REGBITS-1:0]     rf_rq_addr,
    output logic                   rf_w_wr,
    output logic                   rf_rp_rd,
    output logic                   rf_rq_rd,
    output logic [1:0]             rf_s,
    output logic [1:0]             alu_s,
    input  logic                   rf_rp_zero,
    output logic                   halted
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_out_t   out_q;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StInit:   state_d = StFetch;
            StFetch: begin
                ir_d    = i_data;
                state_d = StDecode;
            end
            StDecode: state_d = exec_state(ir_q[15:12]);
            StJmpz:   state_d = rf_rp_zero ? StJmp : StFetch;
`ifdef CTRL_HALT_EN
            StHalt:   state_d = StHalt;
`endif
            default:  state_d = StFetch;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q
    // and never see a combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            ir_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            out_q   <= ctrl_decode(state_d);
        end
    end

`ifdef CTRL_HALT_EN
    logic halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_d == StHalt);
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    ctrl_pc #(
        .PcWidth (PC_WIDTH)
    ) u_pc (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .inc_i    (state_q == StFetch),
        .ld_i     (state_q == StJmp),
        .offset_i (ir_q[7:0]),
        .pc_o     (i_addr)
    );

    assign i_rd       = out_q.i_rd;
    assign d_rd       = out_q.d_rd;
    assign d_wr       = out_q.d_wr;
    assign rf_w_wr    = out_q.rf_w_wr;
    assign rf_rp_rd   = out_q.rf_rp_rd;
    assign rf_rq_rd   = out_q.rf_rq_rd;
    assign rf_s       = out_q.rf_s;
    assign alu_s      = out_q.alu_s;

    assign d_addr     = DADDR_WIDTH'(ir_q[7:0]);
    assign rf_w_data  = ir_q[7:0];
    assign rf_w_addr  = REGBITS'(ir_q[11:8]);
    // ADD/SUB read b on port P; LOAD/STORE/JMPZ read a
    assign rf_rp_addr = out_q.rp_sel_b ? REGBITS'(ir_q[7:4]) : REGBITS'(ir_q[11:8]);
    assign rf_rq_addr = REGBITS'(ir_q[3:0]);

endmodule

// File: tb/tb_ctrl_unit.sv
// Testbench for ctrl_unit: instruction-level reference model with randomized programs.
module tb_ctrl_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_addr;
    logic        i_rd;
    logic [15:0] i_data;
    logic [7:0]  d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [7:0]  rf_w_data;
    logic [3:0]  rf_w_addr;
    logic [3:0]  rf_rp_addr;
    logic [3:0]  rf_rq_addr;
    logic        rf_w_wr;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic [1:0]  rf_s;
    logic [1:0]  alu_s;
    logic        rf_rp_zero;
    logic        halted;

`ifdef CTRL_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] i_addr;
        logic       i_rd;
        logic [7:0] d_addr;
        logic       d_rd;
        logic       d_wr;
        logic [7:0] w_data;
        logic [3:0] w_addr;
        logic [3:0] p_addr;
        logic [3:0] q_addr;
        logic       w_wr;
        logic       p_rd;
        logic       q_rd;
        logic [1:0] rf_s;
        logic [1:0] alu_s;
        logic       halted;
    } vec_t;

    logic [15:0] imem [256];
    logic [7:0]  pc_m;
    int          checks = 0;
    int          errors = 0;

    assign i_data = imem[i_addr];

    ctrl_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_addr     (i_addr),
        .i_rd       (i_rd),
        .i_data     (i_data),
        .d_addr     (d_addr),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .rf_w_data  (rf_w_data),
        .rf_w_addr  (rf_w_addr),
        .rf_rp_addr (rf_rp_addr),
        .rf_rq_addr (rf_rq_addr),
        .rf_w_wr    (rf_w_wr),
        .rf_rp_rd   (rf_rp_rd),
        .rf_rq_rd   (rf_rq_rd),
        .rf_s       (rf_s),
        .alu_s      (alu_s),
        .rf_rp_zero (rf_rp_zero),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t get_obs();
        vec_t v;
        v.i_addr = i_addr;
        v.i_rd   = i_rd;
        v.d_addr = d_addr;
        v.d_rd   = d_rd;
        v.d_wr   = d_wr;
        v.w_data = rf_w_data;
        v.w_addr = rf_w_addr;
        v.p_addr = rf_rp_addr;
        v.q_addr = rf_rq_addr;
        v.w_wr   = rf_w_wr;
        v.p_rd   = rf_rp_rd;
        v.q_rd   = rf_rq_rd;
        v.rf_s   = rf_s;
        v.alu_s  = alu_s;
        v.halted = halted;
        return v;
    endfunction

    // i_addr plus every strobe; fields not listed here are don't-care unless added
    function automatic vec_t strobe_mask();
        vec_t m;
        m = '0;
        m.i_addr = '1;
        m.i_rd   = 1'b1;
        m.d_rd   = 1'b1;
        m.d_wr   = 1'b1;
        m.w_wr   = 1'b1;
        m.p_rd   = 1'b1;
        m.q_rd   = 1'b1;
        m.halted = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input vec_t e, input vec_t m);
        vec_t o;
        o = get_obs();
        checks++;
        assert ((o & m) === (e & m)) else begin
            errors++;
            $error("FAIL %s: observed %h required %h (mask %h)", tag, o & m, e & m, m);
        end
        checks++;
        assert (!(o.w_wr === 1'b1 && o.d_wr === 1'b1)) else begin
            errors++;
            $error("FAIL %s_wr_excl: observed rf_w_wr=%b d_wr=%b required not both 1",
                   tag, o.w_wr, o.d_wr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drop reset (from a non-edge time), check reset values, release, check INIT, enter FETCH.
    task automatic do_reset(input string tag);
        vec_t e;
        rst_n = 1'b0;
        #1;
        e = '0;
        check({tag, "_asserted"}, e, '1);
        @(negedge clk);
        rst_n = 1'b1;
        check({tag, "_init"}, e, strobe_mask());
        step();
        pc_m = 8'h00;
    endtask

    // Runs one instruction at pc_m and checks every cycle it occupies.
    // zsel: 0/1 forces rf_rp_zero in the execute cycle, 2 randomizes it.
    task automatic run_instr(input string tag, input int zsel, input bit abort_exec);
        logic [15:0] ins;
        logic [3:0]  op;
        logic [7:0]  nxt;
        vec_t        e;
        vec_t        m;
        bit          z;
        ins = imem[pc_m];
        op  = ins[15:12];
        nxt = pc_m + 8'd1;

        rf_rp_zero = 1'($urandom_range(0, 1));
        e = '0;
        m = strobe_mask();
        e.i_addr = pc_m;
        e.i_rd   = 1'b1;
        check({tag, "_fetch"}, e, m);
        step();

        rf_rp_zero = 1'($urandom_range(0, 1));
        e = '0;
        e.i_addr = nxt;
        check({tag, "_decode"}, e, m);
        step();

        if (op == 4'hF && HaltEn) begin
            e.halted = 1'b1;
            for (int i = 0; i < 12; i++) begin
                check({tag, "_halt"}, e, m);
                step();
            end
            pc_m = nxt;
            return;
        end
        if (op > 4'h5) begin
            pc_m = nxt;
            return;
        end

        z = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
        rf_rp_zero = z;
        e = '0;
        e.i_addr = nxt;
        case (op)
            4'h0: begin
                e.d_addr = ins[7:0]; e.d_rd = 1'b1; e.rf_s = 2'b01;
                e.w_addr = ins[11:8]; e.w_wr = 1'b1;
                m.d_addr = '1; m.rf_s = '1; m.w_addr = '1;
            end
            4'h1: begin
                e.d_addr = ins[7:0]; e.d_wr = 1'b1; e.p_addr = ins[11:8];
                e.p_rd = 1'b1; e.alu_s = 2'b00;
                m.d_addr = '1; m.p_addr = '1; m.alu_s = '1;
            end
            4'h2, 4'h4: begin
                e.p_addr = ins[7:4]; e.q_addr = ins[3:0]; e.p_rd = 1'b1; e.q_rd = 1'b1;
                e.alu_s = (op == 4'h2) ? 2'b01 : 2'b10; e.rf_s = 2'b00;
                e.w_addr = ins[11:8]; e.w_wr = 1'b1;
                m.p_addr = '1; m.q_addr = '1; m.alu_s = '1; m.rf_s = '1; m.w_addr = '1;
            end
            4'h3: begin
                e.w_data = ins[7:0]; e.rf_s = 2'b10; e.w_addr = ins[11:8]; e.w_wr = 1'b1;
                m.w_data = '1; m.rf_s = '1; m.w_addr = '1;
            end
            default: begin
                e.p_addr = ins[11:8]; e.p_rd = 1'b1;
                m.p_addr = '1;
            end
        endcase
        check({tag, "_exec"}, e, m);
        if (abort_exec) return;
        step();

        if (op == 4'h5 && z) begin
            e = '0;
            e.i_addr = nxt;
            check({tag, "_jmp"}, e, strobe_mask());
            step();
            // Target is the JMPZ's own address plus the signed 8-bit offset
            pc_m = 8'(int'(pc_m) + int'($signed(ins[7:0])));
        end else begin
            pc_m = nxt;
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        rf_rp_zero = 1'b0;
        pc_m       = 8'h00;

        imem[0] = 16'h3105;
        imem[1] = 16'h2312;
        imem[2] = 16'h4312;
        imem[3] = 16'h0210;
        imem[4] = 16'h1210;
        imem[5] = 16'h51FD;
        for (int i = 6; i < 256; i++) begin
            imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end

        #2;
        do_reset("reset");

        run_instr("ldc", 0, 1'b0);
        run_instr("add", 0, 1'b0);
        run_instr("sub", 0, 1'b0);
        run_instr("load", 0, 1'b0);
        run_instr("store", 0, 1'b0);
        run_instr("jmpz_taken", 1, 1'b0);
        run_instr("sub2", 0, 1'b0);
        run_instr("load2", 0, 1'b0);
        run_instr("store2", 0, 1'b0);
        run_instr("jmpz_not_taken", 0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            run_instr("rand", 2, 1'b0);
        end

        imem[8'h00] = 16'h50FF;
        imem[8'hFF] = 16'h5102;
        imem[8'h01] = 16'h2312;
        imem[8'h02] = 16'h5100;
        imem[8'h03] = 16'hF000;
        imem[8'h04] = 16'h3105;
        do_reset("reset2");
        run_instr("jmp_back_to_ff", 1, 1'b0);
        run_instr("wrap_jmpz", 1, 1'b0);
        run_instr("add_after_wrap", 0, 1'b0);
        run_instr("jmpz_self", 1, 1'b0);
        run_instr("jmpz_self_exit", 0, 1'b0);
        run_instr("op_f", 2, 1'b0);
        if (!HaltEn) begin
            run_instr("ldc_after_nop", 0, 1'b0);
        end

        imem[8'h00] = 16'h2312;
        do_reset("reset3");
        run_instr("add_mid_reset", 0, 1'b1);
        #1;
        do_reset("reset_mid_add");
        run_instr("add_after_reset", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
